// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter that shares one SRAM command port between NUM_REQ requesters.
//   A winner holds the port until it issues a beat with req_last=1. Burst locking keeps
//   multi-beat transfers contiguous on the SRAM side. Every accepted read pushes the
//   issuing requester's index into a small ID FIFO. In-order read data is then steered
//   back to that requester in the same cycle it arrives.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester command handshake
//   req_addr          packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wr_en         per-requester 1=write 0=read
//   req_wr_data       packed, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last          final beat of a burst; releases the grant
//   rsp_valid         one-hot read-data valid, rsp_data shared
//   mem_cmd_*         command port towards the SRAM controller
//   mem_rd_valid/data read data return from the SRAM controller, in command order
//   busy              grant held or reads outstanding
//   err               sticky: read data returned with no read outstanding
module sram_rr_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_WIDTH      = 18,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_wr_en,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             mem_cmd_valid,
  input  logic                             mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]            mem_cmd_addr,
  output logic                             mem_cmd_wr_en,
  output logic [DATA_WIDTH-1:0]            mem_cmd_wr_data,
  input  logic                             mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [IdW-1:0]  LastGrantRst = IdW'(NUM_REQ - 1);
  localparam logic [PtrW-1:0] PtrMax       = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW-1:0] CntFull      = CntW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] last_grant_q, last_grant_d;

  // Read-ID FIFO
  logic [IdW-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [IdW-1:0]  head_id;

  // Fields of the currently granted requester
  logic                  locked;
  logic                  g_valid;
  logic                  g_wr;
  logic                  g_last;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  beat_acc;

  // Round-robin search result
  logic           arb_found;
  logic [IdW-1:0] arb_idx;

  // ---------------------------------------------------------------------------------------
  // Arbitration: first valid requester scanning upward from last_grant+1, wrapping.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    logic [IdW-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Command mux
  // ---------------------------------------------------------------------------------------
  assign locked  = (state_q == StLocked);
  assign g_valid = req_valid[grant_q];
  assign g_wr    = req_wr_en[grant_q];
  assign g_last  = req_last[grant_q];
  assign g_addr  = req_addr[grant_q * ADDR_WIDTH +: ADDR_WIDTH];
  assign g_data  = req_wr_data[grant_q * DATA_WIDTH +: DATA_WIDTH];

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);

  // Reads stall while the ID FIFO is full; writes never need an ID slot.
  assign mem_cmd_valid   = locked && g_valid && !(!g_wr && fifo_full);
  assign mem_cmd_addr    = locked ? g_addr : '0;
  assign mem_cmd_wr_en   = locked ? g_wr : 1'b0;
  assign mem_cmd_wr_data = locked ? g_data : '0;

  assign beat_acc = mem_cmd_valid && mem_cmd_ready;

  always_comb begin
    req_ready = '0;
    if (beat_acc) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read-ID FIFO control and response steering
  // ---------------------------------------------------------------------------------------
  // mem_cmd_valid already excludes reads when full, so push never sees a full FIFO.
  assign push    = beat_acc && !g_wr;
  assign pop     = mem_rd_valid && !fifo_empty;
  assign head_id = fifo_mem[rd_ptr_q];

  always_comb begin
    rsp_valid = '0;
    if (pop) begin
      rsp_valid[head_id] = 1'b1;
    end
  end

  assign rsp_data = mem_rd_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Data with no matching read is dropped and flagged until reset.
    if (mem_rd_valid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // ID storage carries no reset; entries are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= grant_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = StLocked;
        end
      end
      StLocked: begin
        // Held until the last beat is accepted, even if req_valid drops mid-burst.
        if (beat_acc && g_last) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastGrantRst;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign busy = locked || !fifo_empty;
  assign err  = err_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed scenarios followed by a randomized phase, all
// checked cycle by cycle against a transaction-level model (grant owner plus a queue of
// outstanding read owners).
module tb_sram_rr_arbiter;

  localparam int NR = 2;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_wr_en;
  logic [NR*DW-1:0] req_wr_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_cmd_valid;
  logic             mem_cmd_ready;
  logic [AW-1:0]    mem_cmd_addr;
  logic             mem_cmd_wr_en;
  logic [DW-1:0]    mem_cmd_wr_data;
  logic             mem_rd_valid;
  logic [DW-1:0]    mem_rd_data;
  logic             busy;
  logic             err;

  sram_rr_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wr_en      (req_wr_en),
    .req_wr_data    (req_wr_data),
    .req_last       (req_last),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd_ready  (mem_cmd_ready),
    .mem_cmd_addr   (mem_cmd_addr),
    .mem_cmd_wr_en  (mem_cmd_wr_en),
    .mem_cmd_wr_data(mem_cmd_wr_data),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: who owns the port, who won last, and the owners of pending reads.
  bit m_locked;
  int m_g;
  int m_last;
  int m_q[$];
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_g      = 0;
    m_last   = NR - 1;
    m_q.delete();
    m_err    = 1'b0;
  endtask

  task automatic clear_inputs();
    req_valid     = '0;
    req_addr      = '0;
    req_wr_en     = '0;
    req_wr_data   = '0;
    req_last      = '0;
    mem_cmd_ready = 1'b1;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input bit last,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_wr_en[i]           = we;
    req_last[i]            = last;
    req_addr[i*AW +: AW]   = a;
    req_wr_data[i*DW +: DW] = d;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model
  // with the inputs that were present at the clock edge.
  task automatic step();
    logic [NR-1:0] e_ready;
    logic [NR-1:0] e_rsp;
    bit            e_mcv;
    bit            acc;
    int            nxt;
    e_ready = '0;
    e_rsp   = '0;
    e_mcv   = 1'b0;
    acc     = 1'b0;
    @(negedge clk);
    if (m_locked) begin
      e_mcv = req_valid[m_g] && !(!req_wr_en[m_g] && m_q.size() == MO);
      acc   = e_mcv && mem_cmd_ready;
      if (acc) e_ready[m_g] = 1'b1;
      chk("cmd_addr", 64'(mem_cmd_addr), 64'(req_addr[m_g*AW +: AW]));
      chk("cmd_wr_en", 64'(mem_cmd_wr_en), 64'(req_wr_en[m_g]));
      chk("cmd_wr_data", 64'(mem_cmd_wr_data), 64'(req_wr_data[m_g*DW +: DW]));
    end
    if (mem_rd_valid && m_q.size() != 0) e_rsp[m_q[0]] = 1'b1;
    chk("mem_cmd_valid", 64'(mem_cmd_valid), 64'(e_mcv));
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_rsp != 0) chk("rsp_data", 64'(rsp_data), 64'(mem_rd_data));
    chk("busy", 64'(busy), 64'(m_locked || m_q.size() != 0));
    chk("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (mem_rd_valid) begin
      if (m_q.size() != 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (acc && !req_wr_en[m_g]) m_q.push_back(m_g);
    if (m_locked) begin
      if (acc && req_last[m_g]) begin
        m_locked = 1'b0;
        m_last   = m_g;
      end
    end else begin
      for (int k = 1; k <= NR; k++) begin
        nxt = (m_last + k) % NR;
        if (req_valid[nxt]) begin
          m_g      = nxt;
          m_locked = 1'b1;
          break;
        end
      end
    end
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with idle inputs
    step();
    step();

    // Both requesters, one-beat writes: grants alternate with an idle cycle between
    set_req(0, 1, 1, 1, 18'h00010, 16'h1111);
    set_req(1, 1, 1, 1, 18'h00020, 16'h2222);
    repeat (10) step();

    // Req1 four-beat read burst while req0 stays valid; req0 must wait
    set_req(0, 1, 1, 1, 18'h00050, 16'h0505);
    set_req(1, 1, 0, 0, 18'h00100, 16'h0000);
    step();
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1, 0, b == 3, AW'(18'h00100 + b), 16'h0000);
      step();
    end
    set_req(1, 0, 0, 0, 18'h0, 16'h0);
    step();
    set_req(0, 0, 1, 1, 18'h00050, 16'h0505);
    for (int b = 0; b < 4; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = DW'(16'hC000 + b);
      step();
    end
    mem_rd_valid = 1'b0;
    set_req(0, 1, 1, 1, 18'h00050, 16'h0505);
    step();
    set_req(0, 0, 0, 0, 18'h0, 16'h0);

    // FIFO full: four reads accepted, fifth stalls until one read returns
    for (int b = 0; b < 5; b++) begin
      set_req(0, 1, 0, b == 4, AW'(18'h00200 + b), 16'h0000);
      if (b == 0) step();
      if (b == 4) begin
        step();
        #1 chk("stall_full", 64'(mem_cmd_valid), 64'(0));
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h1234;
      end
      step();
    end
    mem_rd_valid = 1'b0;
    step();
    set_req(0, 0, 0, 0, 18'h0, 16'h0);
    mem_rd_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_rd_data = DW'(16'h2000 + b);
      step();
    end
    mem_rd_valid = 1'b0;

    // Interleaved reads from req0 then req1: data is routed in issue order
    set_req(0, 1, 0, 1, 18'h00300, 16'h0);
    step();
    step();
    set_req(0, 0, 0, 0, 18'h0, 16'h0);
    set_req(1, 1, 0, 1, 18'h00301, 16'h0);
    step();
    step();
    set_req(1, 0, 0, 0, 18'h0, 16'h0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 16'hAAAA;
    #1 chk("s5_rsp0", 64'(rsp_valid), 64'(2'b01));
    step();
    mem_rd_data = 16'h5555;
    #1 chk("s5_rsp1", 64'(rsp_valid), 64'(2'b10));
    chk("s5_data1", 64'(rsp_data), 64'(16'h5555));
    step();
    mem_rd_valid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        set_req(i, ($urandom % 4) != 0, bit'($urandom % 2), ($urandom % 3) == 0,
                AW'($urandom), DW'($urandom));
      end
      mem_cmd_ready = ($urandom % 4) != 0;
      mem_rd_valid  = (m_q.size() != 0) && (($urandom % 2) != 0);
      mem_rd_data   = DW'($urandom);
      step();
    end

    // Finish any open burst and drain outstanding reads
    clear_inputs();
    for (int c = 0; c < 4 && m_locked; c++) begin
      set_req(m_g, 1, 1, 1, 18'h0, 16'h0);
      step();
    end
    clear_inputs();
    for (int c = 0; c < MO + 2 && m_q.size() != 0; c++) begin
      mem_rd_valid = 1'b1;
      step();
    end
    mem_rd_valid = 1'b0;
    step();

    // Read data with nothing outstanding: dropped, err sticks
    mem_rd_valid = 1'b1;
    mem_rd_data  = 16'hDEAD;
    #1 chk("orphan_rsp", 64'(rsp_valid), 64'(0));
    step();
    mem_rd_valid = 1'b0;
    chk("err_set", 64'(err), 64'(1));
    repeat (3) step();

    // Reset mid-burst with two reads outstanding
    set_req(1, 1, 0, 0, 18'h00400, 16'h0);
    repeat (3) step();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    mem_rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_cmd_valid", 64'(mem_cmd_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    mem_rd_valid = 1'b1;
    #1 chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // After reset req0 has priority
    set_req(0, 1, 1, 1, 18'h00500, 16'h5A5A);
    set_req(1, 1, 1, 1, 18'h00600, 16'hA5A5);
    step();
    #1 chk("post_rst_grant", 64'(req_ready), 64'(2'b01));
    repeat (3) step();
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
